// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem req/ack fetch, valid/ready issue to decode
//
// Holds the program counter. It fetches one instruction at a time from
// instruction memory and hands it to decode. A taken branch downstream can
// redirect the stage; any wrong-path fetch still in flight is discarded.
//
// Ports:
//   CLK, RESETN      single clock; reset is synchronous and active-low
//   imem_req         fetch request, held high until imem_ack
//   imem_addr        registered request address, stable while imem_req is high
//   imem_ack         response strobe from memory (never in a request's first cycle)
//   imem_data        instruction word, valid with imem_ack
//   instr            fetched instruction (opcode at [7:6])
//   instr_pc         address that instr was fetched from
//   instr_valid      instr/instr_pc hold a valid instruction
//   instr_ready      decode accepts instr this cycle
//   redirect         branch taken: flush and refetch from redirect_target
//   redirect_target  new PC
module instr_fetch #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state, state_d;
  logic [PC_WIDTH-1:0]    pc, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] ir, ir_d;
  logic [PC_WIDTH-1:0]    ir_pc, ir_pc_d;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      ir     <= '0;
      ir_pc  <= '0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      addr_q <= addr_d;
      ir     <= ir_d;
      ir_pc  <= ir_pc_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    addr_d  = addr_q;
    ir_d    = ir;
    ir_pc_d = ir_pc;
    case (state)
      // Nothing has been issued yet, so redirect and any stray ack are ignored.
      IDLE: begin
        state_d = REQ;
        addr_d  = pc;
      end
      REQ: begin
        if (redirect) begin
          pc_d = redirect_target;
          if (imem_ack) begin
            // Request just completed: drop the data and reissue at the target.
            addr_d = redirect_target;
          end else begin
            // Outstanding request cannot be withdrawn; wait it out in DRAIN.
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          ir_d    = imem_data;
          ir_pc_d = addr_q;
          pc_d    = addr_q + PC_ONE;
          state_d = VALID;
        end
      end
      VALID: begin
        // Redirect flushes the held instruction even if decode is ready.
        if (redirect) begin
          addr_d  = redirect_target;
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (instr_ready) begin
          addr_d  = pc;
          state_d = REQ;
        end
      end
      DRAIN: begin
        // Latest redirect wins; the wrong-path response is always discarded.
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (imem_ack) begin
          addr_d  = redirect ? redirect_target : pc;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = (state == REQ) || (state == DRAIN);
  assign instr_valid = (state == VALID);
  assign imem_addr   = addr_q;
  assign instr       = ir;
  assign instr_pc    = ir_pc;

endmodule
